// File: rtl/sdram_init.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// Drives the SDRAM command bus through the JEDEC power-up sequence. After
// that it requests the bus from the access controller once per refresh
// interval and issues a single AUTO REFRESH while it holds the grant.
module sdram_init #(
    parameter int          INIT_CYCLES = 5000,
    parameter int          T_RP        = 2,
    parameter int          T_RFC       = 4,
    parameter int          T_MRD       = 2,
    parameter int          N_INIT_REF  = 2,
    parameter int          REF_CYCLES  = 390,
    parameter logic [12:0] MODE        = 13'h020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ref_gnt,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a,
    output logic        own,
    output logic        ready,
    output logic        ref_req,
    output logic        ref_miss
);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOADMODE  = 4'b0000;

    // One timer serves both the power-up wait and the refresh interval.
    localparam int TMAX = (INIT_CYCLES > REF_CYCLES) ? INIT_CYCLES : REF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int NW   = $clog2(N_INIT_REF + 1);
    localparam int HMAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                         : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int HW   = $clog2(HMAX + 1);

    typedef enum logic [3:0] {
        ST_WAIT, ST_PRE, ST_TRP, ST_REF, ST_TRFC, ST_LMR, ST_TMRD,
        ST_IDLE, ST_RREQ, ST_RREF, ST_RWAIT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NW-1:0]   nref_q, nref_d;
    logic            pend_q, pend_d;
    logic            miss_q, miss_d;
    logic            wrap;

    logic            cke_q;
    logic [3:0]      cmd_q;
    logic [1:0]      ba_q;
    logic [12:0]     a_q;
    logic            own_q;
    logic            ready_q;
    logic            req_q;

    // Next-state decisions: sequencing, hold counts, refresh timer and pending/miss flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        nref_d  = nref_q;
        pend_d  = pend_q;
        miss_d  = miss_q;

        // The refresh timer only runs once init is done.
        wrap = ready_q && (timer_q == TW'(REF_CYCLES - 1));
        if (ready_q) begin
            timer_d = wrap ? '0 : timer_q + TW'(1);
            if (wrap) begin
                pend_d = 1'b1;
                if (pend_q) miss_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_WAIT: begin
                if (timer_q == TW'(INIT_CYCLES)) state_d = ST_PRE;
                else                             timer_d = timer_q + TW'(1);
            end
            ST_PRE: begin
                hold_d  = '0;
                nref_d  = '0;
                state_d = (T_RP > 1) ? ST_TRP : ST_REF;
            end
            ST_TRP: begin
                if (hold_q == HW'(T_RP - 2)) state_d = ST_REF;
                else                         hold_d  = hold_q + HW'(1);
            end
            ST_REF: begin
                hold_d = '0;
                nref_d = nref_q + NW'(1);
                if (T_RFC > 1)                            state_d = ST_TRFC;
                else if (nref_q == NW'(N_INIT_REF - 1))   state_d = ST_LMR;
                else                                      state_d = ST_REF;
            end
            ST_TRFC: begin
                if (hold_q == HW'(T_RFC - 2))
                    state_d = (nref_q == NW'(N_INIT_REF)) ? ST_LMR : ST_REF;
                else
                    hold_d = hold_q + HW'(1);
            end
            ST_LMR: begin
                hold_d = '0;
                if (T_MRD > 1) begin
                    state_d = ST_TMRD;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            ST_TMRD: begin
                if (hold_q == HW'(T_MRD - 2)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_IDLE: begin
                // A wrap this cycle counts as pending so ref_req rises with it.
                if (pend_q || wrap) state_d = ST_RREQ;
            end
            ST_RREQ: begin
                if (ref_gnt) begin
                    state_d = ST_RREF;
                    // The refresh now being issued services the pending request;
                    // a wrap landing on it re-arms pending and is not a miss.
                    pend_d  = wrap;
                    miss_d  = miss_q;
                end
            end
            ST_RREF: begin
                hold_d  = '0;
                state_d = (T_RFC > 1) ? ST_RWAIT : ST_IDLE;
            end
            ST_RWAIT: begin
                if (hold_q == HW'(T_RFC - 2)) state_d = ST_IDLE;
                else                          hold_d  = hold_q + HW'(1);
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State registers and registered bus outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_WAIT;
            timer_q <= '0;
            hold_q  <= '0;
            nref_q  <= '0;
            pend_q  <= 1'b0;
            miss_q  <= 1'b0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_INHIBIT;
            ba_q    <= '0;
            a_q     <= '0;
            own_q   <= 1'b1;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            nref_q  <= nref_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            cke_q   <= 1'b1;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            a_q     <= '0;
            unique case (state_d)
                ST_WAIT: cmd_q <= CMD_INHIBIT;
                ST_PRE: begin
                    cmd_q <= CMD_PRECHARGE;
                    a_q   <= 13'h0400;
                end
                ST_REF, ST_RREF: cmd_q <= CMD_REFRESH;
                ST_LMR: begin
                    cmd_q <= CMD_LOADMODE;
                    a_q   <= MODE;
                end
                default: cmd_q <= CMD_NOP;
            endcase
            own_q   <= !(state_d inside {ST_IDLE, ST_RREQ});
            ready_q <= state_d inside {ST_IDLE, ST_RREQ, ST_RREF, ST_RWAIT};
            req_q   <= state_d inside {ST_RREQ, ST_RREF, ST_RWAIT};
        end
    end

    assign sdram_cke = cke_q;
    assign sdram_cmd = cmd_q;
    assign sdram_ba  = ba_q;
    assign sdram_a   = a_q;
    assign own       = own_q;
    assign ready     = ready_q;
    assign ref_req   = req_q;
    assign ref_miss  = miss_q;

endmodule

// File: tb/tb_sdram_init.sv
// Directed bench for sdram_init with small timing parameters.
// Cycle n is the n-th rising edge after reset is sampled low; outputs are
// sampled on the falling edge and inputs are changed there too.
module tb_sdram_init;

    localparam logic [3:0] INH = 4'b1111;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ref_gnt = 1'b0;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic        own, ready, ref_req, ref_miss;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit tie   = 1'b0;

    typedef struct {
        int          cyc;
        bit          gnt;   // ref_gnt driven after this row is checked
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] a;
        logic [1:0]  ba;
        logic        own, ready, req, miss;
    } row_t;

    row_t tbl[$];

    sdram_init #(
        .INIT_CYCLES(10), .T_RP(2), .T_RFC(3), .T_MRD(2),
        .N_INIT_REF(2), .REF_CYCLES(20), .MODE(13'h020)
    ) dut (
        .clk(clk), .reset(reset), .ref_gnt(ref_gnt),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba),
        .sdram_a(sdram_a), .own(own), .ready(ready),
        .ref_req(ref_req), .ref_miss(ref_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (tie) ref_gnt = ref_req;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic check_outs(input logic cke, input logic [3:0] cmd, input logic [12:0] a,
                              input logic own_e, input logic rdy, input logic req, input logic miss);
        check("cke",      32'(sdram_cke), 32'(cke));
        check("cmd",      32'(sdram_cmd), 32'(cmd));
        check("a",        32'(sdram_a),   32'(a));
        check("ba",       32'(sdram_ba),  32'(2'b00));
        check("own",      32'(own),       32'(own_e));
        check("ready",    32'(ready),     32'(rdy));
        check("ref_req",  32'(ref_req),   32'(req));
        check("ref_miss", 32'(ref_miss),  32'(miss));
    endtask

    function automatic row_t mk(int c, bit g, logic cke, logic [3:0] cmd, logic [12:0] a,
                                logic o, logic r, logic q, logic m);
        row_t t;
        t.cyc = c; t.gnt = g; t.cke = cke; t.cmd = cmd; t.a = a; t.ba = 2'b00;
        t.own = o; t.ready = r; t.req = q; t.miss = m;
        return t;
    endfunction

    initial begin
        // Power-up with spurious grant held high through init and idle,
        // then grant held low forever so the second interval is missed.
        tbl.push_back(mk( 0, 1, 0, INH, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk( 1, 1, 1, INH, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk( 5, 1, 1, INH, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(10, 1, 1, INH, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(11, 1, 1, PRE, 13'h400, 1, 0, 0, 0));
        tbl.push_back(mk(12, 1, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(13, 1, 1, REF, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(14, 1, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(15, 1, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(16, 1, 1, REF, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(18, 1, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(19, 1, 1, LMR, 13'h020, 1, 0, 0, 0));
        tbl.push_back(mk(20, 1, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(21, 1, 1, NOP, 13'h000, 0, 1, 0, 0));
        tbl.push_back(mk(30, 1, 1, NOP, 13'h000, 0, 1, 0, 0));
        tbl.push_back(mk(39, 0, 1, NOP, 13'h000, 0, 1, 0, 0));
        tbl.push_back(mk(40, 0, 1, NOP, 13'h000, 0, 1, 0, 0));
        tbl.push_back(mk(41, 0, 1, NOP, 13'h000, 0, 1, 1, 0));
        tbl.push_back(mk(50, 0, 1, NOP, 13'h000, 0, 1, 1, 0));
        tbl.push_back(mk(60, 0, 1, NOP, 13'h000, 0, 1, 1, 0));
        tbl.push_back(mk(61, 0, 1, NOP, 13'h000, 0, 1, 1, 1));
        tbl.push_back(mk(80, 0, 1, NOP, 13'h000, 0, 1, 1, 1));
        tbl.push_back(mk(95, 0, 1, NOP, 13'h000, 0, 1, 1, 1));

        tie = 1'b0;
        ref_gnt = 1'b1;
        do_reset();
        reset = 1'b0;
        foreach (tbl[i]) begin
            run_to(tbl[i].cyc);
            check_outs(tbl[i].cke, tbl[i].cmd, tbl[i].a, tbl[i].own,
                       tbl[i].ready, tbl[i].req, tbl[i].miss);
            ref_gnt = tbl[i].gnt;
        end

        // Refresh with grant tied to request.
        ref_gnt = 1'b0;
        tie = 1'b1;
        do_reset();
        reset = 1'b0;
        run_to(41); check_outs(1, NOP, 13'h000, 0, 1, 1, 0);
        run_to(42); check_outs(1, REF, 13'h000, 1, 1, 1, 0);
        run_to(43); check_outs(1, NOP, 13'h000, 1, 1, 1, 0);
        run_to(44); check_outs(1, NOP, 13'h000, 1, 1, 1, 0);
        run_to(45); check_outs(1, NOP, 13'h000, 0, 1, 0, 0);
        run_to(60); check_outs(1, NOP, 13'h000, 0, 1, 0, 0);
        run_to(61); check_outs(1, NOP, 13'h000, 0, 1, 1, 0);
        run_to(62); check_outs(1, REF, 13'h000, 1, 1, 1, 0);

        // Reset during the refresh: next cycle shows reset values.
        reset = 1'b1;
        tie = 1'b0;
        ref_gnt = 1'b0;
        do_reset();
        check_outs(0, INH, 13'h000, 1, 0, 0, 0);
        reset = 1'b0;

        // Delayed grant: high from cycle 50 until ref_req is seen to fall.
        run_to(49); check_outs(1, NOP, 13'h000, 0, 1, 1, 0);
        run_to(50);
        ref_gnt = 1'b1;
        run_to(51); check_outs(1, REF, 13'h000, 1, 1, 1, 0);
        run_to(52); check_outs(1, NOP, 13'h000, 1, 1, 1, 0);
        run_to(53); check_outs(1, NOP, 13'h000, 1, 1, 1, 0);
        run_to(54); check_outs(1, NOP, 13'h000, 0, 1, 0, 0);
        ref_gnt = 1'b0;
        run_to(61); check_outs(1, NOP, 13'h000, 0, 1, 1, 0);

        // Reset mid-init at cycle 14, then a fresh schedule.
        do_reset();
        reset = 1'b0;
        run_to(13); check_outs(1, REF, 13'h000, 1, 0, 0, 0);
        run_to(14);
        do_reset();
        check_outs(0, INH, 13'h000, 1, 0, 0, 0);
        reset = 1'b0;
        run_to(10); check_outs(1, INH, 13'h000, 1, 0, 0, 0);
        run_to(11); check_outs(1, PRE, 13'h400, 1, 0, 0, 0);
        run_to(13); check_outs(1, REF, 13'h000, 1, 0, 0, 0);
        run_to(19); check_outs(1, LMR, 13'h020, 1, 0, 0, 0);
        run_to(21); check_outs(1, NOP, 13'h000, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
